// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: time-multiplexed driver for a common-anode multi-digit
// seven-segment display. Each digit slot opens with an all-off guard interval
// to suppress ghosting; new values wait in a shadow register and are applied
// only at frame wrap so a displayed frame never tears.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    S_GUARD  = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] disp_dig_q, disp_dig_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

  logic [4*NUM_DIGITS-1:0] sh_dig_q, sh_dig_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic                    pend_q, pend_d;

  logic                    fdone_q, fdone_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic                    slot_end;
  logic                    wrap;
  logic [3:0]              nib;
  logic                    dp_bit;
  logic                    blank_bit;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Slot counter, digit index, shadow capture and frame-boundary transfer.
  always_comb begin
    slot_end     = (cnt_q == CNT_LAST);
    wrap         = slot_end && (idx_q == IDX_LAST);
    cnt_d        = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    disp_dig_d   = disp_dig_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    sh_dig_d     = sh_dig_q;
    sh_dp_d      = sh_dp_q;
    sh_blank_d   = sh_blank_q;
    pend_d       = pend_q;
    fdone_d      = wrap;

    // Display takes the old shadow first; a load on the same edge then
    // refills the shadow and keeps the pending flag set.
    if (wrap && pend_q) begin
      disp_dig_d   = sh_dig_q;
      disp_dp_d    = sh_dp_q;
      disp_blank_d = sh_blank_q;
      pend_d       = 1'b0;
    end
    if (load) begin
      sh_dig_d   = digits_in;
      sh_dp_d    = dp_in;
      sh_blank_d = blank_in;
      pend_d     = 1'b1;
    end
  end

  // Guard/active FSM next state, tracking the counter value about to be held.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_GUARD:  if (cnt_d == GUARD_END) state_d = S_ACTIVE;
      S_ACTIVE: if (slot_end)           state_d = S_GUARD;
      default:                          state_d = S_GUARD;
    endcase
  end

  // Output decode from next-state values so registered outputs line up with
  // the cnt/idx held in the same cycle.
  always_comb begin
    an_d      = '1;
    seg_d     = 7'h7F;
    dp_d      = 1'b1;
    nib       = '0;
    dp_bit    = 1'b0;
    blank_bit = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IDX_W'(k)) begin
        nib       = disp_dig_d[4*k +: 4];
        dp_bit    = disp_dp_d[k];
        blank_bit = disp_blank_d[k];
      end
    end
    if (state_d == S_ACTIVE) begin
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
        if (idx_d == IDX_W'(k)) an_d[k] = 1'b0;
      end
      if (!blank_bit) begin
        seg_d = decode(nib);
        dp_d  = ~dp_bit;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_GUARD;
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_dig_q   <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      sh_dig_q     <= '0;
      sh_dp_q      <= '0;
      sh_blank_q   <= '0;
      pend_q       <= 1'b0;
      fdone_q      <= 1'b0;
      an_q         <= '1;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_dig_q   <= disp_dig_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      sh_dig_q     <= sh_dig_d;
      sh_dp_q      <= sh_dp_d;
      sh_blank_q   <= sh_blank_d;
      pend_q       <= pend_d;
      fdone_q      <= fdone_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
    end
  end

  assign seg            = seg_q;
  assign dp             = dp_q;
  assign an             = an_q;
  assign frame_done     = fdone_q;
  assign update_pending = pend_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner (4 digits, 8-cycle slots, 2-cycle guard).
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SF = 7'b0001110;
  localparam logic [6:0] SOFF = 7'h7F;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   digits_in = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank_in = '0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_done;
  logic          update_pending;

  seven_seg_scanner #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .GUARD_CYC  (GC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load          (load),
    .digits_in     (digits_in),
    .dp_in         (dp_in),
    .blank_in      (blank_in),
    .seg           (seg),
    .dp            (dp),
    .an            (an),
    .frame_done    (frame_done),
    .update_pending(update_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } slot_t;

  slot_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Queue the four slots of one frame; segs packed {d3,d2,d1,d0}, dpo active-low.
  task automatic push_frame(input logic [27:0] segs, input logic [3:0] dpo);
    for (int k = 0; k < ND; k++) begin
      slot_t r;
      r.an     = 4'b1111;
      r.an[k]  = 1'b0;
      r.seg    = segs[7*k +: 7];
      r.dp     = dpo[k];
      exp_q.push_back(r);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 40);
    chk("frame_done_seen", 32'(frame_done), 32'd1);
  endtask

  task automatic load_val(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits_in = d;
    dp_in     = p;
    blank_in  = b;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic       rst_s = 1'b0;
  logic [3:0] prev_an = 4'hF;
  int         act_len = 0;
  int         since_fd = 0;
  slot_t      cur;
  logic       have_cur = 1'b0;

  always @(posedge clk) rst_s <= rst;

  always @(negedge clk) begin
    if (!rst_s) begin
      prev_an  = 4'hF;
      act_len  = 0;
      since_fd = 0;
      have_cur = 1'b0;
    end else begin
      since_fd++;
      if (frame_done) begin
        chk("frame_period", since_fd, 32'd32);
        since_fd = 0;
      end
      chk("an_at_most_one_low", 32'($countones(~an) <= 1), 32'd1);
      if (an == 4'hF) begin
        chk("guard_outputs", {24'd0, seg, dp}, {24'd0, SOFF, 1'b1});
        if (prev_an != 4'hF) begin
          chk("active_len", act_len, 32'd6);
          act_len = 0;
        end
      end else begin
        if (prev_an != 4'hF) chk("anode_no_guard", {28'd0, an}, {28'd0, prev_an});
        if (prev_an == 4'hF) begin
          chk("slot_queued", 32'(exp_q.size() > 0), 32'd1);
          have_cur = 1'b0;
          if (exp_q.size() > 0) begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
          end
        end
        act_len++;
        if (have_cur) chk("slot_out", {20'd0, an, seg, dp}, {20'd0, cur.an, cur.seg, cur.dp});
      end
      prev_an = an;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset
    wait_cycles(3);
    chk("rst_an", {28'd0, an}, 32'hF);
    chk("rst_seg", {25'd0, seg}, {25'd0, SOFF});
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_pend", 32'(update_pending), 32'd0);
    rst = 1'b1;
    push_frame({S0, S0, S0, S0}, 4'b1111);
    @(negedge clk);
    chk("guard_after_rel", {28'd0, an}, 32'hF);
    @(negedge clk);
    chk("first_anode", {28'd0, an}, 32'hE);
    chk("first_seg", {25'd0, seg}, {25'd0, S0});

    // Load mid-frame applies at next wrap
    load_val(16'h1A8F, 4'b0010, 4'b0000);
    chk("pend_after_load", 32'(update_pending), 32'd1);
    wait_frame();
    push_frame({S1, SA, S8, SF}, 4'b1101);
    chk("pend_cleared", 32'(update_pending), 32'd0);

    // Two loads in one frame: last wins
    wait_cycles(2);
    load_val(16'h1111, 4'b0000, 4'b0000);
    wait_cycles(9);
    load_val(16'h2222, 4'b0000, 4'b0000);
    chk("pend_two_loads", 32'(update_pending), 32'd1);
    wait_frame();
    push_frame({S2, S2, S2, S2}, 4'b1111);
    chk("pend_cleared2", 32'(update_pending), 32'd0);

    // Load on the wrap edge while a value is pending
    wait_cycles(3);
    load_val(16'h3333, 4'b0000, 4'b0000);
    chk("pend_3333", 32'(update_pending), 32'd1);
    wait_cycles(27);
    digits_in = 16'h4444;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
    chk("wrap_load_fd", 32'(frame_done), 32'd1);
    push_frame({S3, S3, S3, S3}, 4'b1111);
    chk("pend_kept_on_wrap", 32'(update_pending), 32'd1);
    wait_frame();
    push_frame({S4, S4, S4, S4}, 4'b1111);
    chk("pend_after_4444", 32'(update_pending), 32'd0);

    // Blanked digit keeps its anode but drives segments and dp off
    wait_cycles(2);
    load_val(16'h4444, 4'b1000, 4'b1000);
    wait_frame();
    push_frame({SOFF, S4, S4, S4}, 4'b1111);

    // Mid-slot reset discards the pending shadow
    wait_cycles(2);
    load_val(16'h5555, 4'b0000, 4'b0000);
    chk("pend_5555", 32'(update_pending), 32'd1);
    wait_cycles(8);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_an", {28'd0, an}, 32'hF);
    chk("mid_rst_seg", {25'd0, seg}, {25'd0, SOFF});
    chk("mid_rst_dp", 32'(dp), 32'd1);
    chk("mid_rst_fd", 32'(frame_done), 32'd0);
    chk("mid_rst_pend", 32'(update_pending), 32'd0);
    exp_q.delete();
    rst = 1'b1;
    push_frame({S0, S0, S0, S0}, 4'b1111);
    wait_frame();
    push_frame({S0, S0, S0, S0}, 4'b1111);
    chk("pend_after_rst", 32'(update_pending), 32'd0);
    wait_cycles(28);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Output-side counterpart to the board's input conditioning path: drives a multiplexed, common-anode multi-digit seven-segment display from a packed hex value supplied by the multiplier datapath. It time-multiplexes the anodes with a programmable per-digit slot and inserts an all-off guard interval between digits to suppress ghosting. Loaded values are held in a shadow register and applied only at frame boundaries, so a displayed frame never tears.

Parameters:
NUM_DIGITS, 4, number of digits/anodes scanned (>=2)
REFRESH_DIV, 100000, clk cycles per digit slot (>=2)
GUARD_CYC, 1000, cycles at slot start with all anodes off (1 <= GUARD_CYC < REFRESH_DIV)

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-low
load  in  1  one-cycle strobe capturing digits_in/dp_in/blank_in into the shadow register
digits_in  in  4*NUM_DIGITS  packed hex nibbles; nibble k (bits 4k+3:4k) drives digit k
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
blank_in  in  NUM_DIGITS  per-digit blank, 1 = segments and dp off
seg  out  7  segments, active-low; seg[0]=a … seg[6]=g
dp  out  1  decimal point, active-low
an  out  NUM_DIGITS  anodes, active-low, at most one low at any time
frame_done  out  1  one-cycle pulse at each frame wrap
update_pending  out  1  shadow holds a value not yet applied

Behaviour:
- Synchronous active-low reset: rst==0 at a clk edge sets an=all 1, seg=7'h7F, dp=1, frame_done=0, update_pending=0, slot counter cnt=0, digit index idx=0, display register=0 (digits 0, dp 0, blank 0). Any pending shadow value is discarded. The same applies mid-frame.
- Slot counter: cnt counts 0..REFRESH_DIV-1.
  - At the edge where cnt==REFRESH_DIV-1: cnt←0 and idx←idx+1, wrapping from NUM_DIGITS-1 to 0.
- Two-state FSM per slot:
  - GUARD (cnt < GUARD_CYC): an=all 1, seg=7'h7F, dp=1.
  - ACTIVE (cnt >= GUARD_CYC): an=~(1<<idx), seg=decode(display nibble idx), dp=~dp bit idx. If the blank bit for idx is set, seg=7'h7F and dp=1, but the anode is still driven.
- Output timing: all outputs are registered and reflect the cnt/idx value held in the same cycle.
  - First anode activity after reset release: an=4'b1110 appears GUARD_CYC cycles after the first edge with rst==1.
- Decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Load:
  - load==1 captures all three inputs into the shadow register and sets update_pending=1.
  - A later load before the frame wrap overwrites the shadow; last load wins.
- Frame wrap: the edge where cnt==REFRESH_DIV-1 and idx==NUM_DIGITS-1.
  - frame_done=1 for exactly the following cycle.
  - If update_pending, the display register takes the shadow and update_pending clears.
- Simultaneous load and wrap on the same edge:
  - The display takes the old shadow (if one was pending).
  - The new value goes into the shadow, and update_pending stays at 1.
- No combinational path from any input to any output.

Test Plan:
1. Reset: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYC=2. Hold rst=0 for 3 cycles -> an=4'b1111, seg=7'h7F, dp=1, frame_done=0; after release, an stays 1111 for 2 cycles, then reads 1110 with seg=1000000.
2. Load digits_in=16'h1A8F, dp_in=4'b0010, blank_in=0 mid-frame -> update_pending=1 and the display is unchanged until the wrap. Next frame: digit0 seg=0001110, digit1 seg=0000000 with dp=0, digit2 seg=0001000, digit3 seg=1111001. Each digit is active 6 cycles after a 2-cycle guard; frame_done pulses once every 32 cycles.
3. Two loads in one frame (16'h1111, then 16'h2222) -> the next frame shows all digits seg=0100100; 16'h1111 never appears.
4. Load asserted exactly on the wrap edge while 16'h3333 is pending, with a new value 16'h4444 -> the following frame shows 3s and update_pending=1. The frame after that shows 4s and update_pending=0.
5. blank_in=4'b1000 with dp_in=4'b1000 -> during digit3's active window an=0111, seg=7'h7F, dp=1.
6. rst=0 asserted mid-slot while update_pending=1 -> the next edge gives reset values and update_pending=0. After release the display shows 0000, not the discarded value.
7. Every cycle, checker: an has at most one zero, and never two different anodes low in consecutive cycles without an intervening guard cycle.
